scpad_dram_req_gen: RTL

- Upstream feeder of the scratchpad DRAM request queue.
- Accepts one scheduler tile command (load or store, N rows) and splits each scratchpad row into 64-bit DRAM beats tagged {id, sub_id}.
- For stores, fetches each beat from SRAM before pushing it; for loads, pushes address-only requests.
- Respects queue back-pressure and pulses done once all beats of the command have been accepted.

---
 rtl/scpad_pkg.sv | 29 ++
 rtl/scpad_beat_addr_ctr.sv | 59 +++++
 rtl/scpad_dram_req_gen.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/scpad_pkg.sv
// Shared types and constants for the scratchpad DRAM request path.
package scpad_pkg;

  localparam int unsigned SCPAD_DRAM_ADDR_W = 32;
  localparam int unsigned SCPAD_ID_W        = 4;
  localparam int unsigned SCPAD_SUB_ID_W    = 2;
  localparam int unsigned BEAT_BYTES        = 8;
  localparam int unsigned BEATS_PER_ROW     = 2 ** SCPAD_SUB_ID_W;

  // One DRAM beat request as pushed into the request queue.
  typedef struct packed {
    logic                         write;
    logic [SCPAD_ID_W-1:0]        id;
    logic [SCPAD_SUB_ID_W-1:0]    sub_id;
    logic [SCPAD_DRAM_ADDR_W-1:0] dram_addr;
    logic [7:0]                   num_bytes;
    logic [63:0]                  wdata;
  } dram_beat_req_t;

  // Request generator sequencing states.
  typedef enum logic [2:0] {
    GEN_IDLE,
    GEN_SRAM_RD,
    GEN_WAIT_DATA,
    GEN_ISSUE,
    GEN_DONE
  } gen_state_t;

endpackage

// File: rtl/scpad_beat_addr_ctr.sv
// Row/beat walker: tracks the current row and beat of a tile command and
// produces the matching DRAM beat address and scratchpad row address.
module scpad_beat_addr_ctr #(
  parameter int unsigned DRAM_ADDR_WIDTH = scpad_pkg::SCPAD_DRAM_ADDR_W,
  parameter int unsigned SUB_ID_WIDTH    = scpad_pkg::SCPAD_SUB_ID_W,
  parameter int unsigned ROW_CNT_WIDTH   = 6,
  parameter int unsigned SRAM_ADDR_WIDTH = 10,
  parameter int unsigned BEAT_BYTES      = scpad_pkg::BEAT_BYTES
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       load,
  input  logic                       advance,
  input  logic [DRAM_ADDR_WIDTH-1:0] load_dram_addr,
  input  logic [DRAM_ADDR_WIDTH-1:0] load_stride,
  input  logic [SRAM_ADDR_WIDTH-1:0] load_sram_addr,
  input  logic [ROW_CNT_WIDTH-1:0]   load_num_rows,
  output logic                       last_beat,
  output logic [DRAM_ADDR_WIDTH-1:0] dram_addr,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [SUB_ID_WIDTH-1:0]    beat
);

  logic [ROW_CNT_WIDTH-1:0]   row_cnt;
  logic [ROW_CNT_WIDTH-1:0]   num_rows;
  logic [DRAM_ADDR_WIDTH-1:0] row_base;
  logic [DRAM_ADDR_WIDTH-1:0] stride;
  logic [SRAM_ADDR_WIDTH-1:0] sram_base;

  // Latch the command geometry on load; step beat, and row on beat wrap.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      row_cnt   <= '0;
      num_rows  <= '0;
      beat      <= '0;
      row_base  <= '0;
      stride    <= '0;
      sram_base <= '0;
    end else if (load) begin
      row_cnt   <= '0;
      num_rows  <= load_num_rows;
      beat      <= '0;
      row_base  <= load_dram_addr;
      stride    <= load_stride;
      sram_base <= load_sram_addr;
    end else if (advance) begin
      beat <= beat + SUB_ID_WIDTH'(1);
      if (beat == '1) begin
        row_cnt  <= row_cnt + ROW_CNT_WIDTH'(1);
        row_base <= row_base + stride;
      end
    end
  end

  assign last_beat = (beat == '1) && (row_cnt == num_rows - ROW_CNT_WIDTH'(1));
  assign dram_addr = row_base + DRAM_ADDR_WIDTH'(beat) * DRAM_ADDR_WIDTH'(BEAT_BYTES);
  assign sram_addr = sram_base + SRAM_ADDR_WIDTH'(row_cnt);

endmodule

// File: rtl/scpad_dram_req_gen.sv
// Splits one scheduler tile command into 64-bit DRAM beat requests,
// fetching store data from the scratchpad one beat at a time.
module scpad_dram_req_gen #(
  parameter int unsigned DRAM_ADDR_WIDTH = scpad_pkg::SCPAD_DRAM_ADDR_W,
  parameter int unsigned ID_WIDTH        = scpad_pkg::SCPAD_ID_W,
  parameter int unsigned SUB_ID_WIDTH    = scpad_pkg::SCPAD_SUB_ID_W,
  parameter int unsigned BEAT_BYTES      = scpad_pkg::BEAT_BYTES,
  parameter int unsigned ROW_CNT_WIDTH   = 6,
  parameter int unsigned SRAM_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [ID_WIDTH-1:0]        cmd_id,
  input  logic [DRAM_ADDR_WIDTH-1:0] cmd_dram_addr,
  input  logic [DRAM_ADDR_WIDTH-1:0] cmd_dram_stride,
  input  logic [SRAM_ADDR_WIDTH-1:0] cmd_sram_addr,
  input  logic [ROW_CNT_WIDTH-1:0]   cmd_num_rows,
  output logic                       sram_rd_req,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_rd_addr,
  output logic [SUB_ID_WIDTH-1:0]    sram_rd_beat,
  input  logic                       sram_res_valid,
  input  logic [63:0]                sram_rdata,
  output logic                       req_valid,
  input  logic                       req_ready,
  output logic                       req_write,
  output logic [ID_WIDTH-1:0]        req_id,
  output logic [SUB_ID_WIDTH-1:0]    req_sub_id,
  output logic [DRAM_ADDR_WIDTH-1:0] req_dram_addr,
  output logic [7:0]                 req_num_bytes,
  output logic [63:0]                req_wdata,
  output logic                       busy,
  output logic                       done
);

  import scpad_pkg::*;

  gen_state_t                 state_q;
  gen_state_t                 state_d;
  logic                       write_q;
  logic [ID_WIDTH-1:0]        id_q;
  logic [63:0]                wdata_q;
  logic                       accept;
  logic                       advance;
  logic                       last_beat;
  logic [DRAM_ADDR_WIDTH-1:0] beat_dram_addr;
  logic [SRAM_ADDR_WIDTH-1:0] beat_sram_addr;
  logic [SUB_ID_WIDTH-1:0]    beat;
  dram_beat_req_t             req;

  scpad_beat_addr_ctr #(
    .DRAM_ADDR_WIDTH (DRAM_ADDR_WIDTH),
    .SUB_ID_WIDTH    (SUB_ID_WIDTH),
    .ROW_CNT_WIDTH   (ROW_CNT_WIDTH),
    .SRAM_ADDR_WIDTH (SRAM_ADDR_WIDTH),
    .BEAT_BYTES      (BEAT_BYTES)
  ) u_ctr (
    .clk            (clk),
    .n_rst          (n_rst),
    .load           (accept),
    .advance        (advance),
    .load_dram_addr (cmd_dram_addr),
    .load_stride    (cmd_dram_stride),
    .load_sram_addr (cmd_sram_addr),
    .load_num_rows  (cmd_num_rows),
    .last_beat      (last_beat),
    .dram_addr      (beat_dram_addr),
    .sram_addr      (beat_sram_addr),
    .beat           (beat)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= GEN_IDLE;
    else        state_q <= state_d;
  end

  // Command attributes and store data, held for the whole command.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      write_q <= 1'b0;
      id_q    <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      write_q <= cmd_write;
      id_q    <= cmd_id;
      wdata_q <= '0;
    end else if (state_q == GEN_WAIT_DATA && sram_res_valid) begin
      wdata_q <= sram_rdata;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    sram_rd_req = 1'b0;
    req_valid   = 1'b0;
    accept      = 1'b0;
    advance     = 1'b0;
    case (state_q)
      GEN_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_num_rows == '0) state_d = GEN_DONE;
          else if (cmd_write)     state_d = GEN_SRAM_RD;
          else                    state_d = GEN_ISSUE;
        end
      end
      GEN_SRAM_RD: begin
        busy        = 1'b1;
        sram_rd_req = 1'b1;
        state_d     = GEN_WAIT_DATA;
      end
      GEN_WAIT_DATA: begin
        busy = 1'b1;
        if (sram_res_valid) state_d = GEN_ISSUE;
      end
      GEN_ISSUE: begin
        busy      = 1'b1;
        req_valid = 1'b1;
        if (req_ready) begin
          advance = 1'b1;
          if (last_beat)    state_d = GEN_DONE;
          else if (write_q) state_d = GEN_SRAM_RD;
          else              state_d = GEN_ISSUE;
        end
      end
      GEN_DONE: begin
        done    = 1'b1;
        state_d = GEN_IDLE;
      end
      default: state_d = GEN_IDLE;
    endcase
  end

  // Beat request bundle; driven only while offered so idle outputs stay zero.
  always_comb begin
    req = '0;
    if (state_q == GEN_ISSUE) begin
      req.write     = write_q;
      req.id        = id_q;
      req.sub_id    = beat;
      req.dram_addr = beat_dram_addr;
      req.num_bytes = 8'(BEAT_BYTES);
      req.wdata     = write_q ? wdata_q : '0;
    end
  end

  assign req_write     = req.write;
  assign req_id        = req.id;
  assign req_sub_id    = req.sub_id;
  assign req_dram_addr = req.dram_addr;
  assign req_num_bytes = req.num_bytes;
  assign req_wdata     = req.wdata;

  assign sram_rd_addr  = sram_rd_req ? beat_sram_addr : '0;
  assign sram_rd_beat  = sram_rd_req ? beat : '0;

endmodule
